hazard_control: RTL
===================

Name: hazard_control

Overview:
- Pipeline scheduler for the decode stage.
- Tracks in-flight register-file and IV-latch writes in a shift scoreboard and compares them against the instruction entering decode.
- Generates the `hazard` stall that decode consumes, and sequences bubble insertion (`flush`) after taken control transfers.
- Freezes with the pipeline on `p_cache_miss`, and keeps a saturating stall counter for performance measurement.

Parameters:
- DEPTH, 2, number of pipeline stages between decode output and register/latch write-back (scoreboard entries, 1..4).
- FLUSH_CYCLES, 2, bubbles inserted after a taken JMP/XEC/NZT/CALL/RET (1..7).

Ports:
- clk  in  1  system clock, all state on rising edge
- n_RST  in  1  reset; asynchronous, active-low
- I  in  16  instruction entering decode (same word decode samples)
- p_cache_miss  in  1  program cache miss; freezes all state
- regf_wren  in  1  decode registered regf write enable
- regf_w  in  3  decode registered regf write address
- latch_wren  in  1  decode registered IV-latch write enable
- branch_taken  in  1  one-cycle pulse from PC unit: control transfer taken
- hazard  out  1  stall request to decode/fetch
- flush  out  1  high while bubbles are being inserted
- stall_count  out  16  saturating count of cycles with hazard=1

Behaviour:
- Reset (n_RST=0, async):
  - All scoreboard entries invalid; state=RUN; flush counter=0; hazard_q=0; stall_count=0.
  - hazard=0 and flush=0 while in reset.
- Scoreboard entry k (0..DEPTH-1) holds {rv, ra[2:0], lv}.
  - Each clock with p_cache_miss=0:
    - entry[k] <= entry[k-1] for k>0.
    - entry0 <= {regf_wren, regf_w, latch_wren} when hazard_q=0 and state=RUN; otherwise entry0 <= all zero.
  - hazard_q is the registered hazard. This ensures a held decode instruction is recorded exactly once.
  - p_cache_miss=1: scoreboard, hazard_q, state, counter and stall_count all hold.
- Source extraction, combinational from I:
  - op=I[15:13]; no source when op=6 (XMIT).
  - Otherwise I[11]=0 reads register I[10:8], and I[11]=1 reads the IV bus.
- Hazard, combinational:
  - reg_hit: any valid entry with rv=1 and ra=I[10:8], with I[11]=0 and op!=6.
  - lat_hit: any valid entry with lv=1, with I[11]=1 and op!=6.
  - hazard = (reg_hit | lat_hit) & (state==RUN) & ~branch_taken.
  - hazard clears on its own as bubbles shift the writer out; maximum continuous stall is DEPTH cycles.
- State machine:
  - RUN: branch_taken=1 -> FLUSH, counter <= FLUSH_CYCLES.
  - FLUSH: flush=1, hazard forced 0, counter decrements each non-frozen clock.
    - branch_taken=1 in FLUSH reloads the counter to FLUSH_CYCLES.
    - Counter reaching 1 with no reload -> RUN on that edge.
  - flush = (state==FLUSH), registered.
- stall_count: increments each non-frozen clock with hazard=1; saturates at 16'hFFFF.
- Simultaneous events:
  - p_cache_miss has priority over everything.
  - branch_taken has priority over hazard in the same cycle.
  - Asserting n_RST mid-stall or mid-flush returns to reset values immediately.

Test Plan:
- Reset then idle: n_RST low 3 clk, I=16'h0000 -> hazard=0, flush=0, stall_count=0 throughout.
- Register RAW, DEPTH=2:
  - Cycle 0: regf_wren=1, regf_w=3.
  - Cycle 1: I=16'h0305 (move, src reg 3).
  - Required: hazard=1 for exactly 2 cycles, then 0; stall_count=2; entry0 recorded once.
- Latch RAW: latch_wren=1, next I=16'h2800 (and, I[11]=1) -> hazard=1; the same with I=16'hC800 (XMIT) -> hazard=0.
- Branch flush, FLUSH_CYCLES=2:
  - branch_taken pulse while a reg_hit is pending -> hazard=0 that cycle, flush=1 for exactly 2 cycles.
  - A second pulse during flush extends flush to 2 cycles after that pulse.
- Cache-miss freeze: hazard=1, raise p_cache_miss for 5 clk -> hazard stays 1, stall_count unchanged; hazard clears after the remaining stall cycles once the miss drops.
- Async reset mid-FLUSH: n_RST low between clock edges -> flush=0 and hazard=0 before the next edge; stall_count=0.

Source files
------------

// File: rtl/hazard_control.sv
// Decode-stage hazard scheduler: a shift scoreboard of in-flight register-file and IV-latch
// writes, the RAW stall request, the post-branch bubble sequencer and a stall-cycle counter.
module hazard_control #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        n_RST,
    input  logic [15:0] I,
    input  logic        p_cache_miss,
    input  logic        regf_wren,
    input  logic [2:0]  regf_w,
    input  logic        latch_wren,
    input  logic        branch_taken,
    output logic        hazard,
    output logic        flush,
    output logic [15:0] stall_count
);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   hazard_q, hazard_d;
    logic [15:0]            stall_q, stall_d;
    logic [DEPTH-1:0]       rv_q, rv_d;
    logic [DEPTH-1:0]       lv_q, lv_d;
    logic [DEPTH-1:0][2:0]  ra_q, ra_d;

    logic       has_src;
    logic       src_is_iv;
    logic [2:0] src_reg;
    logic       reg_hit;
    logic       lat_hit;
    logic       unused_bits;

    // XMIT (op 6) has no source operand.
    assign has_src     = (I[15:13] != 3'd6);
    assign src_is_iv   = I[11];
    assign src_reg     = I[10:8];
    assign unused_bits = I[12];

    always_comb begin
        reg_hit = 1'b0;
        lat_hit = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (rv_q[k] && (ra_q[k] == src_reg)) begin
                reg_hit = 1'b1;
            end
            if (lv_q[k]) begin
                lat_hit = 1'b1;
            end
        end
    end

    assign hazard = has_src & (src_is_iv ? lat_hit : reg_hit) &
                    (state_q == StRun) & ~branch_taken;

    assign flush       = (state_q == StFlush);
    assign stall_count = stall_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hazard_d = hazard_q;
        stall_d  = stall_q;
        rv_d     = rv_q;
        lv_d     = lv_q;
        ra_d     = ra_q;

        if (!p_cache_miss) begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                rv_d[k] = rv_q[k-1];
                lv_d[k] = lv_q[k-1];
                ra_d[k] = ra_q[k-1];
            end

            // A stalled decode word must be recorded only on its first cycle; bubbles record nothing.
            if (!hazard_q && (state_q == StRun)) begin
                rv_d[0] = regf_wren;
                ra_d[0] = regf_w;
                lv_d[0] = latch_wren;
            end else begin
                rv_d[0] = 1'b0;
                ra_d[0] = 3'd0;
                lv_d[0] = 1'b0;
            end

            hazard_d = hazard;

            if (hazard && (stall_q != 16'hFFFF)) begin
                stall_d = stall_q + 16'd1;
            end

            unique case (state_q)
                StRun: begin
                    if (branch_taken) begin
                        state_d = StFlush;
                        cnt_d   = FlushLoad;
                    end
                end
                StFlush: begin
                    if (branch_taken) begin
                        cnt_d = FlushLoad;
                    end else if (cnt_q == 3'd1) begin
                        state_d = StRun;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            state_q  <= StRun;
            cnt_q    <= 3'd0;
            hazard_q <= 1'b0;
            stall_q  <= 16'd0;
            rv_q     <= '0;
            lv_q     <= '0;
            ra_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hazard_q <= hazard_d;
            stall_q  <= stall_d;
            rv_q     <= rv_d;
            lv_q     <= lv_d;
            ra_q     <= ra_d;
        end
    end

endmodule
